// File: rtl/psram_xfer_sched_pkg.sv
// psram_xfer_sched_pkg: shared state, request type and defaults
// for the PSRAM transaction scheduler.
package psram_xfer_sched_pkg;

    localparam int SCHED_ADDR_W     = 32;
    localparam int SCHED_LEN_W      = 12;
    localparam int SCHED_PAGE_BYTES = 1024;
    localparam int SCHED_MAX_CHUNK  = 128;
    localparam int SCHED_TCPH_CYC   = 4;

    typedef enum logic [2:0] {
        IDLE,
        CHUNK,
        ISSUE,
        WAIT,
        GAP
    } psram_sched_state_e;

    typedef struct packed {
        logic                    wr;
        logic [SCHED_ADDR_W-1:0] addr;
        logic [SCHED_LEN_W-1:0]  len;
    } psram_sched_req_t;

    function automatic logic [31:0] min3(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] c
    );
        logic [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/psram_xfer_sched_rr2.sv
// psram_sched_rr2: two-requester round-robin arbiter; the pointer
// names the favoured requester and moves only when upd_i is high.
module psram_sched_rr2
    import psram_xfer_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

    logic ptr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q <= 1'b0;
        end else if (upd_i) begin
            ptr_q <= ~last_i;
        end
    end

    always_comb begin
        idx_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
        gnt_o = 2'b00;
        if (|req_i) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/psram_xfer_sched.sv
// psram_xfer_sched: arbitrates two requesters and splits requests into
// page/tCEM-safe engine commands. PSRAM_SCHED_PERF_EN adds perf counters.
module psram_xfer_sched
    import psram_xfer_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = SCHED_ADDR_W,
    parameter int LEN_WIDTH  = SCHED_LEN_W,
    parameter int PAGE_BYTES = SCHED_PAGE_BYTES,
    parameter int MAX_CHUNK  = SCHED_MAX_CHUNK,
    parameter int TCPH_CYC   = SCHED_TCPH_CYC
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [1:0]              req_wr_i,
    input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2*LEN_WIDTH-1:0]  req_len_i,
    output logic [1:0]              req_done_o,
    output logic                    cmd_valid_o,
    input  logic                    cmd_ready_i,
    output logic                    cmd_wr_o,
    output logic [ADDR_WIDTH-1:0]   cmd_addr_o,
    output logic [LEN_WIDTH-1:0]    cmd_len_o,
    output logic                    cmd_src_o,
    input  logic                    done_i,
`ifdef PSRAM_SCHED_PERF_EN
    output logic                    busy_o,
    input  logic                    perf_clr_i,
    output logic [31:0]             perf_cmd_cnt_o,
    output logic [31:0]             perf_stall_cnt_o
`else
    output logic                    busy_o
`endif
);

    localparam int PB_W = $clog2(PAGE_BYTES);
    localparam int RW   = PB_W + 1;
    localparam int GW   = $clog2(TCPH_CYC + 1);

    psram_sched_state_e state_q, state_d;
    psram_sched_req_t   rq;

    logic                  src_q;
    logic [GW-1:0]         gap_q;
    logic [1:0]            gnt;
    logic                  gnt_idx;
    logic                  rr_upd;
    logic                  grant;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [RW-1:0]         page_room;
    logic [LEN_WIDTH-1:0]  chunk;

    psram_sched_rr2 u_rr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .req_i   (req_valid_i),
        .upd_i   (rr_upd),
        .last_i  (src_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx)
    );

    assign grant    = (state_q == IDLE) && (|req_valid_i);
    assign sel_wr   = req_wr_i[gnt_idx];
    assign sel_addr = gnt_idx ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                              : req_addr_i[ADDR_WIDTH-1:0];
    assign sel_len  = gnt_idx ? req_len_i[2*LEN_WIDTH-1:LEN_WIDTH]
                              : req_len_i[LEN_WIDTH-1:0];

    // Only the in-page offset bits decide how far the next page edge is.
    assign page_room = RW'(PAGE_BYTES) - {1'b0, rq.addr[PB_W-1:0]};
    assign chunk     = LEN_WIDTH'(min3(32'(rq.len), 32'(MAX_CHUNK),
                                       32'(page_room)));
    assign busy_o    = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 2'b00;
        req_done_o  = 2'b00;
        cmd_valid_o = 1'b0;
        rr_upd      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    req_ready_o = gnt;
                    state_d     = CHUNK;
                end
            end
            CHUNK: begin
                if (rq.len == '0) begin
                    req_done_o[src_q] = 1'b1;
                    rr_upd            = 1'b1;
                    state_d           = IDLE;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cmd_valid_o = 1'b1;
                if (cmd_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done_i) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    if (rq.len == '0) begin
                        req_done_o[src_q] = 1'b1;
                        rr_upd            = 1'b1;
                        state_d           = IDLE;
                    end else begin
                        state_d = CHUNK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rq         <= '0;
            src_q      <= 1'b0;
            gap_q      <= '0;
            cmd_wr_o   <= 1'b0;
            cmd_addr_o <= '0;
            cmd_len_o  <= '0;
            cmd_src_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        rq.wr   <= sel_wr;
                        rq.addr <= sel_addr;
                        rq.len  <= sel_len;
                        src_q   <= gnt_idx;
                    end
                end
                CHUNK: begin
                    if (rq.len != '0) begin
                        cmd_wr_o   <= rq.wr;
                        cmd_addr_o <= rq.addr;
                        cmd_len_o  <= chunk;
                        cmd_src_o  <= src_q;
                    end
                end
                WAIT: begin
                    if (done_i) begin
                        rq.addr <= rq.addr + ADDR_WIDTH'(cmd_len_o);
                        rq.len  <= rq.len - cmd_len_o;
                        gap_q   <= GW'(TCPH_CYC);
                    end
                end
                GAP: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PSRAM_SCHED_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || perf_clr_i) begin
            perf_cmd_cnt_o   <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (cmd_valid_o && cmd_ready_i) begin
                perf_cmd_cnt_o <= perf_cmd_cnt_o + 32'd1;
            end
            if ((state_q == ISSUE) && !cmd_ready_i) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_psram_xfer_sched.sv
// tb_psram_xfer_sched: randomized bench with an engine stub and a
// chunk-list reference model for the PSRAM scheduler.
module tb_psram_xfer_sched;

    localparam int AW   = 32;
    localparam int LW   = 12;
    localparam int PAGE = 1024;
    localparam int MAXC = 128;
    localparam int TCPH = 4;

    logic          clk, rst_n;
    logic [1:0]    req_valid, req_ready, req_wr, req_done;
    logic [2*AW-1:0] req_addr;
    logic [2*LW-1:0] req_len;
    logic          cmd_valid, cmd_ready, cmd_wr, cmd_src, done, busy;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
`ifdef PSRAM_SCHED_PERF_EN
    logic          perf_clr;
    logic [31:0]   perf_cmd_cnt, perf_stall_cnt;
`endif

    psram_xfer_sched dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_wr_i    (req_wr),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .req_done_o  (req_done),
        .cmd_valid_o (cmd_valid),
        .cmd_ready_i (cmd_ready),
        .cmd_wr_o    (cmd_wr),
        .cmd_addr_o  (cmd_addr),
        .cmd_len_o   (cmd_len),
        .cmd_src_o   (cmd_src),
        .done_i      (done),
`ifdef PSRAM_SCHED_PERF_EN
        .busy_o           (busy),
        .perf_clr_i       (perf_clr),
        .perf_cmd_cnt_o   (perf_cmd_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
`else
        .busy_o      (busy)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        int          l;
        bit          wr;
        bit          src;
        int          start;
        int          acc;
    } cmd_t;

    int   total, bad, cyc_n, vcnt;
    cmd_t cmds[$];
    int   gnt_src[$], gnt_cyc[$], dn_src[$], dn_cyc[$], di_cyc[$];
    bit   in_issue, auto_drop;
    int   cur_start, pend, stall_cfg, stall_left, rr_fav;
    logic [31:0] exp_a[$];
    int   exp_l[$];

    // Reference: walk the request, cutting at MAX_CHUNK and page edges.
    function automatic void model(input logic [31:0] addr, input int len);
        logic [31:0] a = addr;
        int rem = len;
        exp_a.delete();
        exp_l.delete();
        while (rem > 0) begin
            int room = PAGE - int'(a % PAGE);
            int c = rem;
            if (c > MAXC) c = MAXC;
            if (c > room) c = room;
            exp_a.push_back(a);
            exp_l.push_back(c);
            a = a + c;
            rem -= c;
        end
    endfunction

    task automatic clear_logs();
        cmds.delete(); gnt_src.delete(); gnt_cyc.delete();
        dn_src.delete(); dn_cyc.delete(); di_cyc.delete();
        vcnt = 0;
    endtask

    task automatic set_req(input int s, input bit wr,
                           input logic [31:0] addr, input int len);
        req_valid[s] = 1'b1;
        req_wr[s] = wr;
        req_addr[s*AW +: AW] = addr;
        req_len[s*LW +: LW] = LW'(len);
    endtask

    // One clock: observe at negedge (engine stub + logs), drive after posedge.
    task automatic step();
        bit drop [2];
        @(negedge clk);
        cyc_n++;
        for (int i = 0; i < 2; i++) begin
            drop[i] = req_ready[i];
            if (req_ready[i]) begin
                gnt_src.push_back(i); gnt_cyc.push_back(cyc_n);
            end
            if (req_done[i]) begin
                dn_src.push_back(i); dn_cyc.push_back(cyc_n);
            end
        end
        if (done) di_cyc.push_back(cyc_n);
        if (cmd_valid === 1'b1) begin
            vcnt++;
            if (!in_issue) begin
                in_issue = 1'b1; cur_start = cyc_n;
            end
            if (cmd_ready) begin
                cmd_t c;
                c.a = cmd_addr; c.l = int'(cmd_len);
                c.wr = cmd_wr; c.src = cmd_src;
                c.start = cur_start; c.acc = cyc_n;
                cmds.push_back(c);
                in_issue = 1'b0;
                pend = $urandom_range(1, 5);
                stall_left = stall_cfg;
            end else if (stall_left > 0) begin
                stall_left--;
            end
        end
        @(posedge clk);
        #1;
        done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) done = 1'b1;
        end
        cmd_ready = (stall_left == 0);
        for (int i = 0; i < 2; i++) begin
            if (auto_drop && drop[i]) begin
                req_valid[i] = 1'b0;
                req_addr[i*AW +: AW] = $urandom;
                req_len[i*LW +: LW] = LW'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        total++;
        if ({req_ready, req_done, cmd_valid, cmd_wr, cmd_addr,
             cmd_len, cmd_src, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ready=%b done=%b v=%b a=%h l=%0d busy=%b want all 0",
                     req_ready, req_done, cmd_valid, cmd_addr, cmd_len, busy);
        end
        rst_n = 1'b1;
        rr_fav = 0;
        step();
    endtask

    task automatic test_split_read();
        clear_logs();
        model(32'h0, 256);
        set_req(0, 1'b0, 32'h0, 256);
        for (int t = 0; t < 400 && dn_src.size() < 1; t++) step();
        for (int t = 0; t < 20; t++) step();
        total++;
        if (dn_src.size() != 1 || dn_src[0] != 0) begin
            bad++;
            $display("FAIL split_done got %0d pulses want 1 on req0", dn_src.size());
        end
        total++;
        if (cmds.size() != exp_a.size()) begin
            bad++;
            $display("FAIL split_count got %0d want %0d", cmds.size(), exp_a.size());
        end
        for (int i = 0; i < cmds.size() && i < exp_a.size(); i++) begin
            total++;
            if (cmds[i].a !== exp_a[i] || cmds[i].l != exp_l[i] ||
                cmds[i].wr !== 1'b0 || cmds[i].src !== 1'b0) begin
                bad++;
                $display("FAIL split_cmd%0d got %h/%0d want %h/%0d",
                         i, cmds[i].a, cmds[i].l, exp_a[i], exp_l[i]);
            end
        end
        if (cmds.size() == 2 && di_cyc.size() >= 1) begin
            total++;
            if (cmds[1].start - di_cyc[0] < TCPH + 2) begin
                bad++;
                $display("FAIL split_gap got %0d want >=%0d",
                         cmds[1].start - di_cyc[0], TCPH + 2);
            end
        end
        if (cmds.size() >= 1 && gnt_cyc.size() >= 1) begin
            total++;
            if (cmds[0].start - gnt_cyc[0] != 2) begin
                bad++;
                $display("FAIL split_latency got %0d want 2", cmds[0].start - gnt_cyc[0]);
            end
        end
        rr_fav = 1;
    endtask

    task automatic test_page_cross();
        clear_logs();
        model(32'h3F0, 32);
        set_req(1, 1'b1, 32'h3F0, 32);
        for (int t = 0; t < 400 && dn_src.size() < 1; t++) step();
        total++;
        if (dn_src.size() != 1 || dn_src[0] != 1 || cmds.size() != exp_a.size()) begin
            bad++;
            $display("FAIL page_summary got dones=%0d cmds=%0d want 1/%0d",
                     dn_src.size(), cmds.size(), exp_a.size());
        end
        for (int i = 0; i < cmds.size() && i < exp_a.size(); i++) begin
            total++;
            if (cmds[i].a !== exp_a[i] || cmds[i].l != exp_l[i] ||
                cmds[i].wr !== 1'b1 || cmds[i].src !== 1'b1) begin
                bad++;
                $display("FAIL page_cmd%0d got %h/%0d wr=%b src=%b want %h/%0d wr=1 src=1",
                         i, cmds[i].a, cmds[i].l, cmds[i].wr, cmds[i].src,
                         exp_a[i], exp_l[i]);
            end
        end
        rr_fav = 0;
    endtask

    task automatic test_rr();
        int e;
        clear_logs();
        auto_drop = 1'b0;
        set_req(0, 1'b0, $urandom & 32'hFFFF_FFF8, 8);
        set_req(1, 1'b0, $urandom & 32'hFFFF_FFF8, 8);
        for (int t = 0; t < 600 && gnt_src.size() < 4; t++) step();
        req_valid = 2'b00;
        auto_drop = 1'b1;
        for (int t = 0; t < 400 && dn_src.size() < 4; t++) step();
        total++;
        if (gnt_src.size() != 4 || dn_src.size() != 4) begin
            bad++;
            $display("FAIL rr_count got grants=%0d dones=%0d want 4/4",
                     gnt_src.size(), dn_src.size());
        end
        e = rr_fav;
        for (int i = 0; i < gnt_src.size() && i < 4; i++) begin
            total++;
            if (gnt_src[i] != e || (i > 0 && gnt_cyc[i] - gnt_cyc[i-1] < 2)) begin
                bad++;
                $display("FAIL rr_grant%0d got req%0d at +%0d want req%0d single pulse",
                         i, gnt_src[i], i > 0 ? gnt_cyc[i] - gnt_cyc[i-1] : 0, e);
            end
            e = 1 - e;
        end
        if (dn_src.size() > 0) rr_fav = 1 - dn_src[dn_src.size()-1];
    endtask

    task automatic test_stall();
        logic [31:0] a;
        bit w;
        int seen;
        clear_logs();
        a = $urandom & 32'hFFFF_FFF0;
        w = 1'($urandom);
        model(a, 16);
        stall_cfg = 10;
        stall_left = 10;
        seen = 0;
        set_req(1, w, a, 16);
        for (int t = 0; t < 100 && cmds.size() == 0; t++) begin
            step();
            if (cmds.size() == 0 && cmd_valid === 1'b1) begin
                seen++;
                total++;
                if (cmd_addr !== exp_a[0] || int'(cmd_len) != exp_l[0] ||
                    cmd_wr !== w || cmd_src !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_hold got %h/%0d want %h/%0d",
                             cmd_addr, cmd_len, exp_a[0], exp_l[0]);
                end
            end
        end
        total++;
        if (cmds.size() != 1 || cmd_valid !== 1'b0 || seen != 11 ||
            cmds[0].acc - cmds[0].start != 10) begin
            bad++;
            $display("FAIL stall_accept got cmds=%0d valid=%b held=%0d want 1/0/11 at +10",
                     cmds.size(), cmd_valid, seen);
        end
        stall_cfg = 0;
        for (int t = 0; t < 100 && dn_src.size() < 1; t++) step();
        total++;
        if (dn_src.size() != 1 || dn_src[0] != 1) begin
            bad++;
            $display("FAIL stall_done got %0d pulses want 1 on req1", dn_src.size());
        end
        rr_fav = 0;
    endtask

    task automatic test_zero_len();
        clear_logs();
        set_req(0, 1'b0, $urandom, 0);
        for (int t = 0; t < 30 && dn_src.size() < 1; t++) step();
        for (int t = 0; t < 5; t++) step();
        total++;
        if (gnt_src.size() != 1 || dn_src.size() != 1 || dn_src[0] != 0 ||
            dn_cyc[0] - gnt_cyc[0] != 1) begin
            bad++;
            $display("FAIL zero_done got grants=%0d dones=%0d want 1/1 one cycle apart",
                     gnt_src.size(), dn_src.size());
        end
        total++;
        if (vcnt != 0) begin
            bad++;
            $display("FAIL zero_nocmd got %0d valid cycles want 0", vcnt);
        end
        rr_fav = 1;
    endtask

    task automatic test_mid_reset();
        clear_logs();
        set_req(0, 1'b0, $urandom & 32'hFFFF_FFC0, 64);
        for (int t = 0; t < 100 && cmds.size() == 0; t++) step();
        rst_n = 1'b0;
        pend = 0;
        step();
        rst_n = 1'b1;
        in_issue = 1'b0;
        total++;
        if ({req_ready, req_done, cmd_valid, cmd_wr, cmd_addr,
             cmd_len, cmd_src, busy} !== '0 || cmds.size() != 1) begin
            bad++;
            $display("FAIL midrst_outputs got v=%b a=%h busy=%b cmds=%0d want 0 and 1 cmd",
                     cmd_valid, cmd_addr, busy, cmds.size());
        end
        for (int t = 0; t < 30; t++) step();
        total++;
        if (dn_src.size() != 0) begin
            bad++;
            $display("FAIL midrst_nodone got %0d pulses want 0", dn_src.size());
        end
        rr_fav = 0;
        clear_logs();
        set_req(0, 1'b0, 32'h10, 4);
        for (int t = 0; t < 100 && dn_src.size() < 1; t++) step();
        total++;
        if (dn_src.size() != 1 || cmds.size() != 1 ||
            cmds[0].a !== 32'h10 || cmds[0].l != 4) begin
            bad++;
            $display("FAIL midrst_after got dones=%0d cmds=%0d want 1 cmd 00000010/4",
                     dn_src.size(), cmds.size());
        end
        rr_fav = 1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int s = $urandom_range(0, 1);
            bit w = 1'($urandom);
            logic [31:0] a = $urandom;
            int len = $urandom_range(0, 700);
            if (n == 0) begin
                a = 32'hFFFF_FFF0; len = 48;
            end else if (n % 6 == 0) begin
                a = 32'hFFFF_FC00 | ($urandom & 32'h3FF);
            end
            stall_cfg = $urandom_range(0, 3);
            stall_left = stall_cfg;
            model(a, len);
            clear_logs();
            set_req(s, w, a, len);
            for (int t = 0; t < 3000 && dn_src.size() < 1; t++) step();
            step(); step();
            total++;
            if (dn_src.size() != 1 || dn_src[0] != s || cmds.size() != exp_a.size()) begin
                bad++;
                $display("FAIL rnd%0d_summary got dones=%0d cmds=%0d want 1 on req%0d/%0d",
                         n, dn_src.size(), cmds.size(), s, exp_a.size());
            end
            for (int i = 0; i < cmds.size() && i < exp_a.size(); i++) begin
                total++;
                if (cmds[i].a !== exp_a[i] || cmds[i].l != exp_l[i] ||
                    cmds[i].wr !== w || cmds[i].src !== 1'(s) ||
                    (i > 0 && cmds[i].start - di_cyc[i-1] < TCPH + 2) ||
                    (i == 0 && cmds[0].start - gnt_cyc[0] != 2)) begin
                    bad++;
                    $display("FAIL rnd%0d_cmd%0d got %h/%0d wr=%b src=%b want %h/%0d wr=%b src=%0d",
                             n, i, cmds[i].a, cmds[i].l, cmds[i].wr, cmds[i].src,
                             exp_a[i], exp_l[i], w, s);
                end
            end
        end
        stall_cfg = 0;
        stall_left = 0;
    endtask

    initial begin
        total = 0; bad = 0; cyc_n = 0; vcnt = 0;
        in_issue = 1'b0; auto_drop = 1'b1;
        pend = 0; stall_cfg = 0; stall_left = 0; rr_fav = 0; cur_start = 0;
        rst_n = 1'b0;
        req_valid = '0; req_wr = '0; req_addr = '0; req_len = '0;
        cmd_ready = 1'b1; done = 1'b0;
`ifdef PSRAM_SCHED_PERF_EN
        perf_clr = 1'b0;
`endif
        test_reset();
        test_split_read();
        test_page_cross();
        test_rr();
        test_stall();
        test_zero_len();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
